// File: rtl/mdu_e_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, default latencies and small decode helpers.
package mdu_e_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned MULT_CYCLES_DEF  = 5;
  localparam int unsigned DIV_CYCLES_DEF   = 10;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_launch_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// decoded op and flags a divide by zero so the caller can suppress commit.
module mdu_calc
  import mdu_e_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res,
  output logic              div0
);

  // Magnitude of a two's-complement value; INT_MIN maps to 0x80000000,
  // which is exactly its unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic s, input logic [DATA_W-1:0] v);
    return s ? (~v + 1'b1) : v;
  endfunction

  logic signed [2*DATA_W-1:0] w_prod_s;
  logic        [2*DATA_W-1:0] w_prod_u;
  logic        [DATA_W-1:0]   w_b_safe;
  logic        [DATA_W-1:0]   w_mag_a;
  logic        [DATA_W-1:0]   w_mag_b;
  logic        [DATA_W-1:0]   w_uq;
  logic        [DATA_W-1:0]   w_ur;
  logic        [DATA_W-1:0]   w_sq;
  logic        [DATA_W-1:0]   w_sr;
  logic        [DATA_W-1:0]   w_dq;
  logic        [DATA_W-1:0]   w_dr;

  // Signed division goes through magnitudes so INT_MIN / -1 wraps cleanly
  // to INT_MIN with a zero remainder; a zero divisor is replaced by one to
  // keep the dividers X-free (the result is discarded anyway).
  always_comb begin
    w_prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    w_prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    w_b_safe = (b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
    w_mag_a  = mag(a);
    w_mag_b  = mag(w_b_safe);
    w_sq     = neg_if(a[DATA_W-1] ^ w_b_safe[DATA_W-1], w_mag_a / w_mag_b);
    w_sr     = neg_if(a[DATA_W-1], w_mag_a % w_mag_b);
    w_uq     = a / w_b_safe;
    w_ur     = a % w_b_safe;
    w_dq     = (op == MD_DIV) ? w_sq : w_uq;
    w_dr     = (op == MD_DIV) ? w_sr : w_ur;

    hi_res = '0;
    lo_res = '0;
    div0   = 1'b0;
    case (op)
      MD_MULT: begin
        hi_res = w_prod_s[2*DATA_W-1:DATA_W];
        lo_res = w_prod_s[DATA_W-1:0];
      end
      MD_MULTU: begin
        hi_res = w_prod_u[2*DATA_W-1:DATA_W];
        lo_res = w_prod_u[DATA_W-1:0];
      end
      MD_DIV, MD_DIVU: begin
        hi_res = w_dr;
        lo_res = w_dq;
        div0   = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit. Owns HI/LO, latches the result at
// launch and commits it after a fixed busy latency; md_stall lets the
// hazard unit hold md-class instructions in decode.
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        md_op,
  input  logic              start,
  input  logic [DATA_W-1:0] RS_E,
  input  logic [DATA_W-1:0] RT_E,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy,
  output logic              md_stall
);

  mdu_state_e        r_state;
  mdu_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] r_hi_pend;
  logic [DATA_W-1:0] r_lo_pend;
  logic              r_div0_pend;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              w_load;
  logic              w_commit;
  logic              w_mthi;
  logic              w_mtlo;
  logic [DATA_W-1:0] w_hi_res;
  logic [DATA_W-1:0] w_lo_res;
  logic              w_div0;

  mdu_calc u_calc (
    .op     (md_op),
    .a      (RS_E),
    .b      (RT_E),
    .hi_res (w_hi_res),
    .lo_res (w_lo_res),
    .div0   (w_div0)
  );

  // Next-state decode: launch or move-to from IDLE, count down in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && is_launch_op(md_op)) begin
          w_load      = 1'b1;
          w_cnt_nxt   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_state_nxt = ST_RUN;
        end else if (md_op == MD_MTHI) begin
          w_mthi = 1'b1;
        end else if (md_op == MD_MTLO) begin
          w_mtlo = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pending result captured at launch, held until the commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi_pend   <= '0;
      r_lo_pend   <= '0;
      r_div0_pend <= 1'b0;
    end else if (w_load) begin
      r_hi_pend   <= w_hi_res;
      r_lo_pend   <= w_lo_res;
      r_div0_pend <= w_div0;
    end
  end

  // Architectural HI/LO: commit of a finished op (unless divide by zero) or MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_div0_pend) begin
        r_hi <= r_hi_pend;
        r_lo <= r_lo_pend;
      end
    end else begin
      if (w_mthi) r_hi <= RS_E;
      if (w_mtlo) r_lo <= RS_E;
    end
  end

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign busy     = (r_state == ST_RUN);
  assign md_stall = start | busy;

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: latency, arithmetic corner cases, move-to
// ops, ignored starts while busy, mid-operation reset and md_stall.
module tb_mdu_e;
  import mdu_e_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic        start;
  logic [31:0] RS_E;
  logic [31:0] RT_E;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;

  int n_vec = 0;
  int n_err = 0;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .start    (start),
    .RS_E     (RS_E),
    .RT_E     (RT_E),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a launch for one cycle; returns at the negedge after the launch edge.
  task automatic launch(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    RS_E  = a;
    RT_E  = b;
    start = 1'b1;
    #1;
    chk({tag, "_stall_start"}, {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  // Expect n busy cycles, then idle with the given HI/LO.
  task automatic wait_commit(input string tag, input int n,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      step();
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_MTHI;
    RS_E  = 32'hFFFF_FFFF;
    RT_E  = 32'h0;
    @(negedge clk);
    step();
    step();
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    md_op = MD_NONE;
    #1;
    chk("stall_idle", {31'd0, md_stall}, 32'd0);

    launch("mult", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("mult_stall_busy", {31'd0, md_stall}, 32'd1);
    wait_commit("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    launch("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_commit("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

    launch("div", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_commit("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch("divu", MD_DIVU, 32'h0000_0007, 32'h0000_0002);
    wait_commit("divu", 10, 32'h0000_0001, 32'h0000_0003);

    launch("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit("div_ovf", 10, 32'h0000_0000, 32'h8000_0000);

    md_op = MD_MTHI;
    RS_E  = 32'h11;
    step();
    chk("mthi_preset", HI, 32'h11);
    md_op = MD_MTLO;
    RS_E  = 32'h22;
    step();
    chk("mtlo_preset", LO, 32'h22);
    md_op = MD_NONE;
    launch("div0", MD_DIVU, 32'h0000_0005, 32'h0000_0000);
    wait_commit("div0", 10, 32'h11, 32'h22);

    md_op = MD_MTHI;
    RS_E  = 32'hDEAD_BEEF;
    step();
    chk("mthi", HI, 32'hDEAD_BEEF);
    md_op = MD_NONE;
    launch("busy_ign", MD_MULT, 32'h0001_0000, 32'h0003_0000);
    chk("busy_ign_b1", {31'd0, busy}, 32'd1);
    md_op = MD_MTLO;
    RS_E  = 32'h0000_1234;
    step();
    chk("busy_ign_b2", {31'd0, busy}, 32'd1);
    chk("mtlo_ignored", LO, 32'h22);
    chk("hi_hold", HI, 32'hDEAD_BEEF);
    md_op = MD_MULT;
    RS_E  = 32'h7;
    RT_E  = 32'h7;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = MD_NONE;
    wait_commit("busy_ign", 3, 32'h0000_0003, 32'h0000_0000);

    md_op = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = MD_NONE;
    chk("bad_op_ignored", {31'd0, busy}, 32'd0);

    launch("abort", MD_MULT, 32'h3, 32'h4);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (8) step();
    chk("abort_nocommit_lo", LO, 32'h0);
    chk("abort_nocommit_busy", {31'd0, busy}, 32'd0);
    chk("stall_idle_end", {31'd0, md_stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
